// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings for the data-memory access controller
package dm_pkg;

  // Default word-index width of the data memory (1024 words)
  localparam int DM_ADDR_W = 10;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } dm_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_ERR   = 3'd4
  } dm_state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// rtl/dm_lane_unit.sv - byte/halfword lane select, extend, merge and alignment check
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] load_val,
  output logic        misalign
);

  dm_op_e     op_e;
  logic [7:0] lane_byte;
  logic [15:0] lane_half;

  assign op_e = dm_op_e'(op);

  // Little-endian lane pick from the memory word
  always_comb begin
    lane_byte = word[7:0];
    case (addr_lo)
      2'd0: lane_byte = word[7:0];
      2'd1: lane_byte = word[15:8];
      2'd2: lane_byte = word[23:16];
      2'd3: lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
    lane_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Load extension; stores produce zero so the response data stays clean
  always_comb begin
    load_val = '0;
    case (op_e)
      OP_LW:  load_val = word;
      OP_LH:  load_val = {{16{lane_half[15]}}, lane_half};
      OP_LHU: load_val = {16'h0000, lane_half};
      OP_LB:  load_val = {{24{lane_byte[7]}}, lane_byte};
      OP_LBU: load_val = {24'h000000, lane_byte};
      default: load_val = '0;
    endcase
  end

  // Store merge: replace only the addressed lane of the word just read
  always_comb begin
    merged = word;
    case (op_e)
      OP_SH: merged = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      OP_SB: begin
        case (addr_lo)
          2'd0: merged = {word[31:8], wdata[7:0]};
          2'd1: merged = {word[31:16], wdata[7:0], word[7:0]};
          2'd2: merged = {word[31:24], wdata[7:0], word[15:0]};
          2'd3: merged = {wdata[7:0], word[23:0]};
          default: merged = word;
        endcase
      end
      default: merged = word;
    endcase
  end

  // Word ops need a word boundary, halfword ops an even address, bytes never fault
  always_comb begin
    misalign = 1'b0;
    case (op_e)
      OP_LW, OP_SW:         misalign = (addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: misalign = addr_lo[0];
      default:              misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_rmw_ctrl.sv
// rtl/dm_rmw_ctrl.sv - MEM-stage to word-memory controller with sub-word read-modify-write
module dm_rmw_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       trace_pc,
  output logic [31:0]       trace_addr
);

  dm_state_e   state;
  dm_state_e   state_next;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic        is_idle;
  logic [2:0]  lane_op;
  logic [1:0]  lane_addr;
  logic [31:0] merged_word;
  logic [31:0] load_val;
  logic        misalign;

  assign is_idle = (state == S_IDLE);

  // In IDLE the lane unit sees the incoming request so its misalign flag can steer
  // the accept; in every other state it works on the latched request only, and the
  // data outputs are ignored in IDLE.
  assign lane_op   = is_idle ? req_op : op_q;
  assign lane_addr = is_idle ? req_addr[1:0] : addr_q[1:0];

  dm_lane_unit u_lane (
    .op       (lane_op),
    .addr_lo  (lane_addr),
    .word     (mem_rdata),
    .wdata    (wdata_q[15:0]),
    .merged   (merged_word),
    .load_val (load_val),
    .misalign (misalign)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request on accept; held until the next accept
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else if (is_idle && req_valid) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
    end
  end

  // Next-state: full-word stores skip the read, sub-word ops read first
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (misalign) begin
            state_next = S_ERR;
          end else if (req_op == OP_SW) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_RD:    state_next = S_MERGE;
      S_MERGE: state_next = S_IDLE;
      S_WR:    state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and latched request; suppressed during reset so an
  // interrupted RMW never writes or responds
  always_comb begin
    req_ready  = is_idle;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    if (!reset) begin
      case (state)
        S_MERGE: begin
          resp_valid = 1'b1;
          if (op_q == OP_SH || op_q == OP_SB) begin
            mem_we    = 1'b1;
            mem_wdata = merged_word;
          end else begin
            resp_rdata = load_val;
          end
        end
        S_WR: begin
          resp_valid = 1'b1;
          mem_we     = 1'b1;
          mem_wdata  = wdata_q;
        end
        S_ERR: begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
        end
        default: begin
          resp_valid = 1'b0;
        end
      endcase
    end
  end

  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign trace_pc   = pc_q;
  assign trace_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_dm_rmw_ctrl.sv
// tb/tb_dm_rmw_ctrl.sv - scoreboard bench for dm_rmw_ctrl with a registered-read memory
module tb_dm_rmw_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;

  dm_rmw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .trace_pc   (trace_pc),
    .trace_addr (trace_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] taddr;
  } wr_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          resp_count = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic bit model_mis(input logic [2:0] op, input logic [1:0] a);
    if (op == OP_LW || op == OP_SW) return (a != 2'b00);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * int'(a));
    case (op)
      OP_LW:  return w;
      OP_LH:  return {{16{sh[15]}}, sh[15:0]};
      OP_LHU: return {16'h0, sh[15:0]};
      OP_LB:  return {{24{sh[7]}}, sh[7:0]};
      OP_LBU: return {24'h0, sh[7:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] m;
    int          s;
    if (op == OP_SW) return d;
    if (op == OP_SH) begin
      s = 16 * int'(a[1]);
      m = 32'h0000FFFF << s;
      return (w & ~m) | ((d & 32'h0000FFFF) << s);
    end
    s = 8 * int'(a);
    m = 32'h000000FF << s;
    return (w & ~m) | ((d & 32'h000000FF) << s);
  endfunction

  // Word memory: registered read, write on mem_we
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare each response and each memory write
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    int   a;
    if (resp_valid) begin
      resp_count++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check_val("resp_latency", cyc - a + 1, e.lat);
      end
    end
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        check_val("unexpected_we", 32'd1, 32'd0);
      end else begin
        w = wr_q.pop_front();
        check_val("we_addr", {22'd0, mem_addr}, {22'd0, w.idx});
        check_val("we_data", mem_wdata, w.data);
        check_val("trace_pc", trace_pc, w.pc);
        check_val("trace_addr", trace_addr, w.taddr);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input bit hold, input bit track);
    exp_t        e;
    wr_t         w;
    logic [9:0]  idx;
    logic [31:0] word;
    bit          mis;
    idx  = addr[11:2];
    word = ref_mem[idx];
    mis  = model_mis(op, addr[1:0]);
    if (track) begin
      e.err   = mis;
      e.rdata = mis ? 32'h0 : model_load(op, addr[1:0], word);
      e.lat   = (mis || op == OP_SW) ? 1 : 2;
      exp_q.push_back(e);
      if (!mis && (op == OP_SW || op == OP_SH || op == OP_SB)) begin
        w.idx   = idx;
        w.data  = model_store(op, addr[1:0], word, wd);
        w.pc    = pc;
        w.taddr = {addr[31:2], 2'b00};
        ref_mem[idx] = w.data;
        wr_q.push_back(w);
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_pc    = pc;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    if (!req_ready) check_val("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (track) acc_q.push_back(cyc);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || wr_q.size() != 0); i++) begin
      @(negedge clk);
      #1;
    end
    check_val("drain_pending", exp_q.size() + wr_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] ad;
    int          r0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[3]     = 32'h8899AABB;
    ref_mem[3] = 32'h8899AABB;

    // Reset state, while reset is held and just after release
    repeat (3) @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_ready", {31'd0, req_ready}, 32'd1);
    check_val("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("idle_resp_err", {31'd0, resp_err}, 32'd0);
    check_val("idle_rdata", resp_rdata, 32'd0);
    check_val("idle_wdata", mem_wdata, 32'd0);
    check_val("idle_trace_pc", trace_pc, 32'd0);
    check_val("idle_trace_addr", trace_addr, 32'd0);

    // Loads from the preloaded word
    issue(OP_LB,  32'h0000000D, 32'h0, 32'h1000, 0, 1);
    drain();
    issue(OP_LBU, 32'h0000000D, 32'h0, 32'h1004, 0, 1);
    drain();
    issue(OP_LH,  32'h0000000E, 32'h0, 32'h1008, 0, 1);
    drain();

    // Sub-word stores through read-modify-write
    issue(OP_SB, 32'h0000000F, 32'h12345678, 32'h100C, 0, 1);
    drain();
    check_val("mem3_after_sb", mem[3], 32'h7899AABB);
    issue(OP_SW, 32'h0000000C, 32'h8899AABB, 32'h1010, 0, 1);
    drain();
    issue(OP_SH, 32'h0000000C, 32'h0000BEEF, 32'h1014, 0, 1);
    drain();
    check_val("mem3_after_sh", mem[3], 32'h8899BEEF);
    issue(OP_LW, 32'h0000000C, 32'h0, 32'h1018, 0, 1);
    drain();

    // Misaligned store: error at +1, memory untouched
    issue(OP_SW, 32'h0000000E, 32'hCAFEF00D, 32'h101C, 0, 1);
    drain();
    check_val("mem3_after_err", mem[3], 32'h8899BEEF);

    // Reset during the read phase of an SB
    issue(OP_SB, 32'h0000000D, 32'hDEADBEEF, 32'h1020, 0, 0);
    reset = 1'b1;
    check_val("rd_cycle_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check_val("mem3_after_rst", mem[3], 32'h8899BEEF);

    // Back-to-back SW then LW with req_valid held
    r0 = resp_count;
    issue(OP_SW, 32'h00000010, 32'hA5A55A5A, 32'h1024, 1, 1);
    @(negedge clk);
    check_val("busy_ready", {31'd0, req_ready}, 32'd0);
    issue(OP_LW, 32'h00000010, 32'h0, 32'h1028, 0, 1);
    drain();
    check_val("b2b_resp_count", resp_count - r0, 32'd2);

    // Random mix, high address bits set to exercise wrap
    for (int n = 0; n < 60; n++) begin
      ad = $urandom & 32'hFFFF_F03F;
      pc = 32'h2000 + 4 * n;
      issue(3'($urandom_range(0, 7)), ad, $urandom, pc, ($urandom_range(0, 1) == 1), 1);
    end
    req_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) check_val("final_mem", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
